// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES-128 key scheduler.
// Loads a 128-bit cipher key and hands out round keys 0..10 over a
// valid/ready handshake. Rcon and SubWord are external combinational units.
// Optional macro KEY_EXP_REVERSE_EN adds a `decrypt` input and an 11-entry
// key buffer so the keys can be emitted 10 down to 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; round_key_valid low
// LOAD  | key 0 just registered; presented to the consumer
// EMIT  | presenting round key round_key_index, advancing on handshake
// FILL  | reverse mode only: computing keys 0..10 into the buffer, valid low
module key_expansion_seq #(
   parameter int WORD = 32,
   parameter int Nb   = 128,
   parameter int Nr   = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [Nb-1:0]   key_in,
   output logic [3:0]      round_number,
   input  logic [WORD-1:0] rcon_in,
   output logic [WORD-1:0] subword_out,
   input  logic [WORD-1:0] subword_in,
   output logic [Nb-1:0]   round_key,
   output logic [3:0]      round_key_index,
   output logic            round_key_valid,
   input  logic            round_key_ready,
`ifdef KEY_EXP_REVERSE_EN
   input  logic            decrypt,
`endif
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT, FILL} state_t;

   localparam logic [3:0] LAST_IDX = 4'(Nr);

   state_t          state_q, state_d;
   logic [Nb-1:0]   key_q, key_d;
   logic [3:0]      idx_q, idx_d;
   logic            done_q, done_d;

   logic [WORD-1:0] w0, w1, w2, w3;
   logic [WORD-1:0] temp, n0, n1, n2, n3;
   logic [Nb-1:0]   next_key;
   logic            handshake;

`ifdef KEY_EXP_REVERSE_EN
   logic            rev_q, rev_d;
   logic            filled_q, filled_d;
   logic            buf_we;
   logic [Nb-1:0]   key_buf_q [0:10];
`endif

   // One round of the key schedule, purely combinational from the current key.
   always_comb begin
      w0       = key_q[127:96];
      w1       = key_q[95:64];
      w2       = key_q[63:32];
      w3       = key_q[31:0];
      subword_out = {w3[23:0], w3[31:24]};
      temp     = subword_in ^ rcon_in;
      n0       = w0 ^ temp;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   assign round_number    = idx_q + 4'd1;
   assign round_key       = key_q;
   assign round_key_index = idx_q;
   assign round_key_valid = (state_q == LOAD) || (state_q == EMIT);
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign handshake       = round_key_valid && round_key_ready;

   // Next-state, next-key and index sequencing.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
`ifdef KEY_EXP_REVERSE_EN
      rev_d    = rev_q;
      filled_d = filled_q;
      buf_we   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key_in;
               idx_d   = 4'd0;
               state_d = LOAD;
`ifdef KEY_EXP_REVERSE_EN
               rev_d    = decrypt;
               filled_d = 1'b0;
               if (decrypt) state_d = FILL;
`endif
            end
         end
         LOAD, EMIT: begin
            // LOAD already presents key 0, so it accepts a handshake like EMIT.
            state_d = EMIT;
            if (handshake) begin
`ifdef KEY_EXP_REVERSE_EN
               if (rev_q) begin
                  if (idx_q == 4'd0) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q - 4'd1;
                     key_d = key_buf_q[idx_q - 4'd1];
                  end
               end else
`endif
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  key_d = next_key;
                  idx_d = idx_q + 4'd1;
               end
            end
         end
`ifdef KEY_EXP_REVERSE_EN
         FILL: begin
            // Key k is written one edge after it appears; the last write sets
            // filled, and the following edge starts emitting key 10 (still in key_q).
            if (filled_q) begin
               state_d = EMIT;
            end else begin
               buf_we = 1'b1;
               if (idx_q == LAST_IDX) begin
                  filled_d = 1'b1;
               end else begin
                  key_d = next_key;
                  idx_d = idx_q + 4'd1;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Control and key registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
`ifdef KEY_EXP_REVERSE_EN
         rev_q    <= 1'b0;
         filled_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
`ifdef KEY_EXP_REVERSE_EN
         rev_q    <= rev_d;
         filled_q <= filled_d;
`endif
      end
   end

`ifdef KEY_EXP_REVERSE_EN
   // Reverse-order key store; data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (buf_we) key_buf_q[idx_q] <= key_q;
   end
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// Testbench for key_expansion_seq. Provides the Rcon and SubWord units
// behaviourally and checks round keys against a word-wise key schedule model.
module tb_key_expansion_seq;

   logic          clk = 1'b0;
   logic          rst, start, ready, decrypt;
   logic [127:0]  key_in, round_key;
   logic [3:0]    round_number, idx;
   logic [31:0]   rcon_in, sw_out, sw_in;
   logic          valid, busy, done;

   int n_checks = 0;
   int n_errors = 0;

   logic [127:0] exp_keys [0:10];
   logic [127:0] obs_keys [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   always #5 clk = ~clk;

   key_expansion_seq dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .key_in          (key_in),
      .round_number    (round_number),
      .rcon_in         (rcon_in),
      .subword_out     (sw_out),
      .subword_in      (sw_in),
      .round_key       (round_key),
      .round_key_index (idx),
      .round_key_valid (valid),
      .round_key_ready (ready),
`ifdef KEY_EXP_REVERSE_EN
      .decrypt         (decrypt),
`endif
      .busy            (busy),
      .done            (done)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse then affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      logic [7:0] p = a;
      logic [7:0] b;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      b = (a == 8'h00) ? 8'h00 : r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   function automatic logic [31:0] rcon_f(input logic [3:0] n);
      logic [7:0] rc = 8'h01;
      if (n < 4'd1 || n > 4'd10) return 32'h0;
      for (int i = 1; i < int'(n); i++) rc = gf_mul(rc, 8'h02);
      return {rc, 24'h0};
   endfunction

   assign sw_in   = sub_word(sw_out);
   assign rcon_in = rcon_f(round_number);

   // FIPS-197 word-wise expansion: 44 words, w[i] = w[i-4] ^ temp.
   task automatic build_model(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ rcon_f(4'(i / 4));
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
   task automatic run(input logic [127:0] key, input int mode, input bit dec, input bit start_now);
      int pos = 0;
      int stalls = 0;
      int nvalid = 0;
      int first = dec ? 12 : 0;
      int exp_i;
      int c;
      bit seen = 1'b0;
      build_model(key);
      if (!start_now) @(negedge clk);
      start = 1'b1; key_in = key; decrypt = dec; ready = 1'b0;
      @(negedge clk);
      start = 1'b0; key_in = rand_key();
      for (c = 0; c < 300 && pos < 11; c++) begin
         if (c > 0) @(negedge clk);
         if (valid) begin
            if (!seen) begin
               seen = 1'b1;
               chk("first_valid_cycle", c, first);
            end
            exp_i = dec ? 10 - pos : pos;
            chk("index", idx, exp_i);
            chk("round_key", round_key, exp_keys[exp_i]);
            chk("busy_emit", busy, 1'b1);
            if (exp_i < 10) chk("round_number", round_number, exp_i + 1);
            case (mode)
               0:       ready = 1'b1;
               1:       ready = (nvalid % 4 == 0) || (nvalid % 4 == 3);
               default: ready = 1'($urandom_range(0, 1));
            endcase
            nvalid++;
            if (ready) begin
               obs_keys[exp_i] = round_key;
               pos++;
            end else begin
               stalls++;
            end
         end else begin
            chk("busy_prevalid", busy, 1'b1);
            chk("valid_only_low_in_fill", c < first, 1'b1);
            ready = 1'($urandom_range(0, 1));
         end
      end
      if (pos < 11) begin
         chk("timeout_keys_accepted", pos, 11);
      end else begin
         @(negedge clk);
         ready = 1'b0;
         chk("done", done, 1'b1);
         chk("busy_done", busy, 1'b0);
         chk("valid_done", valid, 1'b0);
         chk("done_cycle", c, first + 11 + stalls);
      end
   endtask

   task automatic busy_reset_test();
      logic [127:0] key_a = rand_key();
      logic [127:0] key_b = rand_key();
      build_model(key_a);
      @(negedge clk);
      start = 1'b1; key_in = key_a; decrypt = 1'b0; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("bz_index", idx, k);
         chk("bz_key", round_key, exp_keys[k]);
         start  = (k == 2);
         key_in = key_b;
         @(negedge clk);
      end
      start = 1'b0;
      chk("bz_index5", idx, 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_round_key", round_key, 128'h0);
      chk("rst_index", idx, 4'd0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      run(key_b, 0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ready = 1'b0; key_in = '0; decrypt = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_round_key", round_key, 128'h0);
      chk("reset_index", idx, 4'd0);
      chk("reset_valid", valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      rst = 1'b0;

      run(FIPS_KEY, 0, 1'b0, 1'b0);
      chk("fips_k0", obs_keys[0], FIPS_KEY);
      chk("fips_k1", obs_keys[1], FIPS_K1);
      chk("fips_k10", obs_keys[10], FIPS_K10);

      // Started in the done cycle of the previous run.
      run(128'h0, 0, 1'b0, 1'b1);
      chk("zero_k1", obs_keys[1], ZERO_K1);
      chk("zero_k10", obs_keys[10], ZERO_K10);

      run(rand_key(), 1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) run(rand_key(), 2, 1'b0, 1'($urandom_range(0, 1)));

      busy_reset_test();

`ifdef KEY_EXP_REVERSE_EN
      run(FIPS_KEY, 0, 1'b1, 1'b0);
      chk("rev_fips_k10", obs_keys[10], FIPS_K10);
      chk("rev_fips_k0", obs_keys[0], FIPS_KEY);
      run(rand_key(), 2, 1'b1, 1'b0);
      run(rand_key(), 1, 1'b1, 1'b1);
      run(rand_key(), 2, 1'b0, 1'b0);
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/key_expansion_seq.md
# key_expansion_seq

Sequential AES-128 key scheduler. It loads a 128-bit cipher key and emits the 11 round keys (indices 0..10), one per accepted valid/ready handshake, to the round datapath. It sits directly downstream of the Rcon block: it drives Rcon's 4-bit round number and consumes its 32-bit constant. S-box lookup is external: one shared combinational SubWord unit is wired through the `subword_*` ports.

## Interface
- `WORD`, 32, word width in bits
- `Nb`, 128, key and round-key width in bits
- `Nr`, 10, last round-key index

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin expansion; accepted only while `busy`=0
- `key_in` in 128: cipher key, sampled on the `start` edge
- `round_number` out 4: to Rcon
- `rcon_in` in 32: from Rcon, combinational response to `round_number`
- `subword_out` out 32: RotWord of the current w3, to the external SubWord unit
- `subword_in` in 32: SubWord result, combinational
- `round_key` out 128: current round key, {w0,w1,w2,w3}, w0 in MSBs
- `round_key_index` out 4: index of `round_key`, 0..10
- `round_key_valid` out 1: `round_key` is valid
- `round_key_ready` in 1: consumer accepts the key
- `busy` out 1: expansion in progress
- `done` out 1: one-cycle pulse after key 10 is accepted
- `decrypt` in 1: present only with `KEY_EXP_REVERSE_EN`; sampled on the `start` edge

Clocking and reset are fixed: one clock; reset is synchronous and active-high.

## Operation
- FSM states and transitions:
  - IDLE -> LOAD on `start`.
  - LOAD -> EMIT.
  - EMIT -> EMIT on each handshake.
  - EMIT -> IDLE after the handshake for index 10.
- Reverse mode adds FILL (see Configuration).
- LOAD: register `key_in` as round key 0, index 0. `round_key_valid` is 1 from the LOAD edge onward.
- Key generation for the next key:
  - `subword_out` = {w3[23:0], w3[31:24]}.
  - temp = `subword_in` ^ `rcon_in`.
  - w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - The XOR chain is single-cycle combinational.
- `round_number` = `round_key_index`+1 (4-bit, combinational from the index register). It is a don't-care at index 10.
- Handshake: `round_key_valid`&&`round_key_ready` at an edge accepts the key. The next key and the index+1 are registered on that same edge.
- Backpressure: while valid&&!ready, `round_key` and `round_key_index` hold stable.
- `done` is asserted for the one cycle following acceptance of index 10. In that cycle `busy`=0, `round_key_valid`=0, and the state is IDLE.
- `start` with `busy`=1 is ignored. `start` in the `done` cycle is accepted.
- `rst` at any time, including mid-expansion, forces IDLE on the next edge.
- Reset values: `round_key`=0, `round_key_index`=0, `round_key_valid`=0, `busy`=0, `done`=0.

## Timing
- `start` high at edge T -> `round_key_valid`=1, index 0, `round_key`=`key_in` after T.
- With `round_key_ready` held high, index k appears after edge T+k, for k=0..10. `done` is high after edge T+11.
- Total with no backpressure: 11 valid cycles, then 1 `done` cycle.
- Each stalled cycle adds exactly one cycle of latency.
- `busy`=1 from after edge T until the edge that presents `done`.
- Combinational paths: index register -> Rcon -> XOR chain, and w3 -> SubWord -> XOR chain. Both are register-to-register within one cycle.

## Configuration
- Macro `KEY_EXP_REVERSE_EN`.
- Defined:
  - Adds the `decrypt` port and an internal 11x128 key buffer.
  - With `decrypt`=1 at `start`: state FILL stores keys 0..10 internally with `round_key_valid`=0, storing key k at the edge after T+k+1.
  - After FILL completes, `round_key_valid` rises after edge T+12 presenting index 10.
  - Keys are then emitted 10 down to 0 under the same handshake. `done` follows acceptance of index 0.
  - With `decrypt`=0, behaviour is identical to forward mode.
- Undefined: no `decrypt` port and no buffer; forward order only.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> index 0 = key, index 1 = a0fafe1788542cb123a339392a6c7605, index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; `done` after T+11; `round_number` steps 1..10.
- All-zero key -> index 1 = 62636363626363636263636362636363, index 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Ready toggled 1,0,0,1 repeatedly -> key and index stable during low cycles; sequence is unchanged; `done` is delayed exactly by the stall count.
- `start` pulsed while `busy`, and `rst` asserted at index 5 -> the pulse is ignored; after reset all outputs are 0. A new `start` restarts from index 0 with the new key.
- `start` asserted in the `done` cycle -> new expansion begins with index 0 after that edge.
- `KEY_EXP_REVERSE_EN`, `decrypt`=1, FIPS key -> valid first after T+12 with index 10 = d014…0ca6. The last key emitted is index 0 = 2b7e…4f3c, followed by `done`.
